// File: rtl/beep_pkg.sv
// Shared types and helpers for the lift tool beep sequencer.
// Tier encodings, sequencer states and beep period derivation.
package beep_pkg;

    localparam int CNT_W = 27;

    localparam logic [2:0] TIER_LEVEL = 3'd0;
    localparam logic [2:0] TIER_1     = 3'd1;
    localparam logic [2:0] TIER_2     = 3'd2;
    localparam logic [2:0] TIER_3     = 3'd3;
    localparam logic [2:0] TIER_4     = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    // Full beep period (ON + OFF) in clk cycles for a tier.
    function automatic logic [CNT_W-1:0] period_of(
        input logic [2:0] t,
        input int         clk_hz
    );
        logic [CNT_W-1:0] p;
        p = '0;
        case (t)
            TIER_1:  p = CNT_W'(clk_hz / 2);
            TIER_2:  p = CNT_W'(clk_hz / 3);
            TIER_3:  p = CNT_W'(clk_hz / 4);
            TIER_4:  p = CNT_W'(clk_hz / 10);
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/beep_rate_controller_tone.sv
// Audio tone square wave for the buzzer.
// Restartable half-period divider with a toggle flop, low outside ON.
module tone_gen #(
    parameter int TONE_DIV = 12_500
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tone
);

    localparam int W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [W-1:0] RELOAD = W'(TONE_DIV - 1);

    logic [W-1:0] cnt;

    // Half-period countdown; tone starts low on every restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (restart) begin
            cnt  <= RELOAD;
            tone <= 1'b0;
        end else if (en) begin
            if (cnt == '0) begin
                cnt  <= RELOAD;
                tone <= ~tone;
            end else begin
                cnt <= cnt - W'(1);
            end
        end else begin
            cnt  <= '0;
            tone <= 1'b0;
        end
    end

endmodule

// File: rtl/beep_rate_controller.sv
// Audible level indicator: tilt to tier with hysteresis,
// then an ON/OFF beep cadence gating a tone onto the buzzer.
module beep_rate_controller
    import beep_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TONE_DIV = 12_500,
    parameter int T1       = 5,
    parameter int T2       = 10,
    parameter int T3       = 20,
    parameter int T4       = 30,
    parameter int HYST     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tilt_mag,
    input  logic       tilt_valid,
    input  logic       mute,
    output logic [2:0] tier,
    output logic       beep_on,
    output logic       buzzer,
    output logic       busy
);

    localparam logic [7:0] T1_B = 8'(T1);
    localparam logic [7:0] T2_B = 8'(T2);
    localparam logic [7:0] T3_B = 8'(T3);
    localparam logic [7:0] T4_B = 8'(T4);
    localparam logic signed [8:0] HYST_S = 9'(HYST);

    localparam logic [CNT_W-1:0] P1 = period_of(TIER_1, CLK_HZ);
    localparam logic [CNT_W-1:0] P2 = period_of(TIER_2, CLK_HZ);
    localparam logic [CNT_W-1:0] P3 = period_of(TIER_3, CLK_HZ);
    localparam logic [CNT_W-1:0] P4 = period_of(TIER_4, CLK_HZ);

    localparam logic [CNT_W-1:0] ON1 = P1 >> 1;
    localparam logic [CNT_W-1:0] ON2 = P2 >> 1;
    localparam logic [CNT_W-1:0] ON3 = P3 >> 1;
    localparam logic [CNT_W-1:0] ON4 = P4 >> 1;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    localparam logic [CNT_W-1:0] ON1_LD  = ON1 - ONE;
    localparam logic [CNT_W-1:0] ON2_LD  = ON2 - ONE;
    localparam logic [CNT_W-1:0] ON3_LD  = ON3 - ONE;
    localparam logic [CNT_W-1:0] ON4_LD  = ON4 - ONE;
    localparam logic [CNT_W-1:0] OFF1_LD = P1 - ON1 - ONE;
    localparam logic [CNT_W-1:0] OFF2_LD = P2 - ON2 - ONE;
    localparam logic [CNT_W-1:0] OFF3_LD = P3 - ON3 - ONE;
    localparam logic [CNT_W-1:0] OFF4_LD = P4 - ON4 - ONE;

    logic [2:0]             target;
    logic [7:0]             thr_cur;
    logic signed [8:0]      lower_lim;
    logic                   drop;
    logic [2:0]             tier_d;

    state_t                 state;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_d;
    logic [2:0]             applied;
    logic [2:0]             applied_d;
    logic [CNT_W-1:0]       on_ld;
    logic [CNT_W-1:0]       off_ld;

    logic                   tone_en;
    logic                   tone_restart;

    // Target tier and the hysteresis floor of the current tier.
    always_comb begin
        target = 3'(tilt_mag >= T1_B)
               + 3'(tilt_mag >= T2_B)
               + 3'(tilt_mag >= T3_B)
               + 3'(tilt_mag >= T4_B);
        thr_cur = 8'd0;
        case (tier)
            TIER_1:  thr_cur = T1_B;
            TIER_2:  thr_cur = T2_B;
            TIER_3:  thr_cur = T3_B;
            TIER_4:  thr_cur = T4_B;
            default: thr_cur = 8'd0;
        endcase
        lower_lim = $signed({1'b0, thr_cur}) - HYST_S;
        drop = (target < tier)
            && ($signed({1'b0, tilt_mag}) < lower_lim);
        tier_d = tier;
        if (tilt_valid && ((target > tier) || drop)) begin
            tier_d = target;
        end
    end

    // Tracked tier register, updated only from valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            tier <= TIER_LEVEL;
        end else begin
            tier <= tier_d;
        end
    end

    // Phase reload values: ON from the tracked tier, OFF from the applied one.
    always_comb begin
        on_ld = '0;
        case (tier)
            TIER_1:  on_ld = ON1_LD;
            TIER_2:  on_ld = ON2_LD;
            TIER_3:  on_ld = ON3_LD;
            TIER_4:  on_ld = ON4_LD;
            default: on_ld = '0;
        endcase
        off_ld = '0;
        case (applied)
            TIER_1:  off_ld = OFF1_LD;
            TIER_2:  off_ld = OFF2_LD;
            TIER_3:  off_ld = OFF3_LD;
            TIER_4:  off_ld = OFF4_LD;
            default: off_ld = '0;
        endcase
    end

    // Sequencer next state, phase counter and applied-tier latch.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        applied_d = applied;
        unique case (state)
            IDLE: begin
                if (!mute && (tier != TIER_LEVEL)) begin
                    applied_d = tier;
                    cnt_d     = on_ld;
                    state_d   = ON;
                end
            end
            ON: begin
                if (mute) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt == '0) begin
                    cnt_d   = off_ld;
                    state_d = OFF;
                end else begin
                    cnt_d = cnt - ONE;
                end
            end
            OFF: begin
                if (mute) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt == '0) begin
                    applied_d = tier;
                    if (tier == TIER_LEVEL) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = on_ld;
                        state_d = ON;
                    end
                end else begin
                    cnt_d = cnt - ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered beep_on/busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            applied <= TIER_LEVEL;
            beep_on <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            applied <= applied_d;
            beep_on <= (state_d == ON);
            busy    <= (state_d != IDLE);
        end
    end

    assign tone_en      = (state_d == ON);
    assign tone_restart = (state_d == ON) && (state != ON);

    tone_gen #(
        .TONE_DIV (TONE_DIV)
    ) u_tone (
        .clk     (clk),
        .rst     (rst),
        .en      (tone_en),
        .restart (tone_restart),
        .tone    (buzzer)
    );

endmodule

// File: tb/tb_beep_rate_controller.sv
// Self-checking bench for beep_rate_controller.
// Timeline model of tier and beep cadence plus directed literal checks.
module tb_beep_rate_controller;

    localparam int CLK_HZ   = 1000;
    localparam int TONE_DIV = 5;
    localparam int HYST     = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tilt_mag;
    logic       tilt_valid;
    logic       mute;
    logic [2:0] tier;
    logic       beep_on;
    logic       buzzer;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    beep_rate_controller #(
        .CLK_HZ   (CLK_HZ),
        .TONE_DIV (TONE_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tilt_mag   (tilt_mag),
        .tilt_valid (tilt_valid),
        .mute       (mute),
        .tier       (tier),
        .beep_on    (beep_on),
        .buzzer     (buzzer),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int thr [5] = '{0, 5, 10, 20, 30};

    int m_tier = 0;
    int m_k    = 0;
    int m_on   = 0;
    int m_len  = 0;
    bit m_act  = 1'b0;
    bit chk_en = 1'b0;

    function automatic int period(input int t);
        case (t)
            1:       return CLK_HZ / 2;
            2:       return CLK_HZ / 3;
            3:       return CLK_HZ / 4;
            4:       return CLK_HZ / 10;
            default: return 0;
        endcase
    endfunction

    function automatic void check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        compared++;
        if (act !== exp) begin
            mismatched++;
            if (mismatched <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         name, act, exp, $time);
        end
    endfunction

    // Model: beep timeline measured from the start of each period.
    always @(posedge clk) begin
        int old_t;
        int tgt;
        if (rst) begin
            m_tier = 0;
            m_act  = 1'b0;
            m_k    = 0;
        end else begin
            old_t = m_tier;
            if (m_act) begin
                if (mute) begin
                    m_act = 1'b0;
                end else begin
                    m_k++;
                    if (m_k == m_len) begin
                        if (old_t == 0) begin
                            m_act = 1'b0;
                        end else begin
                            m_k   = 0;
                            m_len = period(old_t);
                            m_on  = m_len / 2;
                        end
                    end
                end
            end else if (!mute && old_t != 0) begin
                m_act = 1'b1;
                m_k   = 0;
                m_len = period(old_t);
                m_on  = m_len / 2;
            end
            if (tilt_valid) begin
                tgt = 0;
                for (int i = 1; i < 5; i++)
                    if (int'(tilt_mag) >= thr[i]) tgt++;
                if (tgt > m_tier)
                    m_tier = tgt;
                else if (tgt < m_tier &&
                         int'(tilt_mag) < thr[m_tier] - HYST)
                    m_tier = tgt;
            end
        end
        chk_en = 1'b1;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        bit e_on;
        bit e_buz;
        if (chk_en) begin
            e_on  = m_act && (m_k < m_on);
            e_buz = e_on && (((m_k / TONE_DIV) % 2) == 1);
            check("cyc_tier", 32'(tier), 32'(m_tier));
            check("cyc_beep_on", 32'(beep_on), 32'(e_on));
            check("cyc_buzzer", 32'(buzzer), 32'(e_buz));
            check("cyc_busy", 32'(busy), 32'(m_act));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int v);
        tilt_mag   = 8'(v);
        tilt_valid = 1'b1;
        tick(1);
        tilt_valid = 1'b0;
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (beep_on === lvl && n < 2000) begin
            n++;
            tick(1);
        end
    endtask

    task automatic wait_rise();
        int n;
        n = 0;
        while (beep_on === 1'b1 && n < 2000) begin
            n++;
            tick(1);
        end
        while (beep_on !== 1'b1 && n < 2000) begin
            n++;
            tick(1);
        end
        if (n >= 2000) check("rise_timeout", 32'(beep_on), 32'd1);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        tilt_mag   = 8'd0;
        tilt_valid = 1'b0;
        mute       = 1'b0;

        // 1. reset with random inputs
        for (int i = 0; i < 3; i++) begin
            tilt_mag   = 8'($urandom);
            tilt_valid = 1'($urandom);
            mute       = 1'($urandom);
            tick(1);
        end
        check("rst_tier", 32'(tier), 32'd0);
        check("rst_beep", 32'(beep_on), 32'd0);
        check("rst_buzzer", 32'(buzzer), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst        = 1'b0;
        tilt_valid = 1'b0;
        mute       = 1'b0;
        tick(20);
        check("quiet_tier", 32'(tier), 32'd0);
        check("quiet_busy", 32'(busy), 32'd0);

        // 2. cadence at tier 2
        strobe(12);
        check("t2_tier", 32'(tier), 32'd2);
        check("t2_not_yet", 32'(beep_on), 32'd0);
        tick(1);
        check("t2_rise", 32'(beep_on), 32'd1);
        check("t2_buz_c1", 32'(buzzer), 32'd0);
        tick(4);
        check("t2_buz_c5", 32'(buzzer), 32'd0);
        tick(1);
        check("t2_buz_c6", 32'(buzzer), 32'd1);
        run_len(1'b1, n);
        check("t2_on_rest", 32'(n), 32'd161);
        run_len(1'b0, n);
        check("t2_off", 32'(n), 32'd167);
        run_len(1'b1, n);
        check("t2_on2", 32'(n), 32'd166);

        // 3. hysteresis
        strobe(9);
        check("hyst_9", 32'(tier), 32'd2);
        strobe(8);
        check("hyst_8", 32'(tier), 32'd2);
        strobe(7);
        check("hyst_7", 32'(tier), 32'd1);
        wait_rise();
        run_len(1'b1, n);
        check("t1_on", 32'(n), 32'd250);
        run_len(1'b0, n);
        check("t1_off", 32'(n), 32'd250);
        strobe(35);
        check("jump_4", 32'(tier), 32'd4);

        // 4. mid-beep tier change
        strobe(12);
        check("back_2", 32'(tier), 32'd2);
        wait_rise();
        tick(39);
        strobe(35);
        check("mid_tier", 32'(tier), 32'd4);
        run_len(1'b1, n);
        check("mid_on_rest", 32'(n), 32'd126);
        run_len(1'b0, n);
        check("mid_off", 32'(n), 32'd167);
        run_len(1'b1, n);
        check("t4_on", 32'(n), 32'd50);
        run_len(1'b0, n);
        check("t4_off", 32'(n), 32'd50);

        // 5. mute
        strobe(12);
        check("mute_t2", 32'(tier), 32'd2);
        wait_rise();
        tick(9);
        mute = 1'b1;
        tick(1);
        check("mute_beep", 32'(beep_on), 32'd0);
        check("mute_buz", 32'(buzzer), 32'd0);
        check("mute_busy", 32'(busy), 32'd0);
        strobe(22);
        check("mute_track3", 32'(tier), 32'd3);
        strobe(12);
        check("mute_track2", 32'(tier), 32'd2);
        tick(10);
        check("mute_idle", 32'(busy), 32'd0);
        mute = 1'b0;
        tick(1);
        check("unmute_rise", 32'(beep_on), 32'd1);
        run_len(1'b1, n);
        check("unmute_on", 32'(n), 32'd166);

        // 6. level during OFF, then reset mid-OFF
        strobe(0);
        check("level_tier", 32'(tier), 32'd0);
        tick(300);
        check("level_busy", 32'(busy), 32'd0);
        check("level_beep", 32'(beep_on), 32'd0);
        strobe(12);
        tick(1);
        check("rs_rise", 32'(beep_on), 32'd1);
        run_len(1'b1, n);
        check("rs_on", 32'(n), 32'd166);
        tick(20);
        rst = 1'b1;
        tick(1);
        check("rs_tier", 32'(tier), 32'd0);
        check("rs_beep", 32'(beep_on), 32'd0);
        check("rs_buz", 32'(buzzer), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(600);
        check("rs_after_busy", 32'(busy), 32'd0);
        check("rs_after_beep", 32'(beep_on), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
